nested_index_gen: RTL and testbench

- Parametrised two-level loop index generator: successor to the single-index sweep counter in the matrix datapath.
- Produces row index i and column index j over a runtime-sized R×C grid, one element per consumed cycle, with start/restart, stall, row-end and completion signalling.
- Sits between the sequencing controller and the address generators of the element-wise and matrix-vector units.

---
 rtl/nested_idx_pkg.sv | 15 +
 rtl/nested_index_gen_wrap_counter.sv | 39 +++
 rtl/nested_index_gen.sv | 138 +++++++++++++
 tb/tb_nested_index_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/nested_idx_pkg.sv
// rtl/nested_idx_pkg.sv - shared types and defaults for the nested index generator
//
// Contents:
//   state_t            : sweep FSM encoding (ST_IDLE, ST_RUN)
//   DEFAULT_SIZE_ADDR  : default index/bound width
package nested_idx_pkg;

  localparam int DEFAULT_SIZE_ADDR = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/nested_index_gen_wrap_counter.sv
// rtl/nested_index_gen_wrap_counter.sv - loadable index counter with terminal-count compare
//
// Module wrap_counter: W-bit register, synchronous clear, increment that wraps to
// zero once the value has reached the supplied limit.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous clear to zero (wins over i_inc)
//   i_inc          : advance by one, or wrap to zero when at the limit
//   i_limit        : terminal value (inclusive)
//   o_value        : current count
//   o_at_limit     : o_value == i_limit
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_value,
  output logic         o_at_limit
);

  logic [W-1:0] r_value;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= '0;
    end else if (i_clr) begin
      r_value <= '0;
    end else if (i_inc) begin
      r_value <= o_at_limit ? '0 : r_value + 1'b1;
    end
  end

  assign o_value    = r_value;
  assign o_at_limit = (r_value == i_limit);

endmodule

// File: rtl/nested_index_gen.sv
// rtl/nested_index_gen.sv - two-level (row, column) loop index generator
//
// Sweeps (i, j) over an R x C grid in row-major order, one pair per consumed cycle.
// Optional build macro: NESTED_IDX_TRIANGULAR_EN (lower triangle j = 0..i, R only).
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_start                  : start/restart a sweep, latches bounds (wins over i_en)
//   i_en                     : consumer accepts the current pair
//   i_num_rows, i_num_cols   : bounds R, C, sampled only with i_start
//   o_valid                  : current pair valid (FSM in RUN)
//   o_step                   : o_valid & i_en & ~i_start, index advances on this edge
//   o_row_i, o_col_j         : current indices
//   o_row_last               : current column is the last of its row (qualified by o_valid)
//   o_busy                   : FSM in RUN
//   o_done                   : registered one-cycle pulse after the last pair is consumed
module nested_index_gen
  import nested_idx_pkg::*;
#(
  parameter int SIZE_ADDR = DEFAULT_SIZE_ADDR
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_en,
  input  logic [SIZE_ADDR-1:0] i_num_rows,
  input  logic [SIZE_ADDR-1:0] i_num_cols,
  output logic                 o_valid,
  output logic                 o_step,
  output logic [SIZE_ADDR-1:0] o_row_i,
  output logic [SIZE_ADDR-1:0] o_col_j,
  output logic                 o_row_last,
  output logic                 o_busy,
  output logic                 o_done
);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_done;
  logic                 w_done_next;
  logic [SIZE_ADDR-1:0] r_last_row;
  logic [SIZE_ADDR-1:0] w_col_limit;
  logic                 w_zero_size;
  logic                 w_row_at_limit;
  logic                 w_col_at_limit;
  logic                 w_last_elem;
  logic                 w_col_inc;
  logic                 w_row_inc;

`ifdef NESTED_IDX_TRIANGULAR_EN
  // Inner bound follows the row index, so the column count input plays no part.
  assign w_zero_size = (i_num_rows == '0);
  assign w_col_limit = o_row_i;
`else
  logic [SIZE_ADDR-1:0] r_last_col;

  assign w_zero_size = (i_num_rows == '0) || (i_num_cols == '0);
  assign w_col_limit = r_last_col;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_col <= '0;
    end else if (i_start && !w_zero_size) begin
      r_last_col <= i_num_cols - 1'b1;
    end
  end
`endif

  // Bounds are stored as R-1 / C-1 so the counters never need a value of R or C,
  // which keeps the maximum bound within SIZE_ADDR bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_row <= '0;
    end else if (i_start && !w_zero_size) begin
      r_last_row <= i_num_rows - 1'b1;
    end
  end

  assign o_valid     = (r_state == ST_RUN);
  assign o_busy      = (r_state == ST_RUN);
  assign o_step      = o_valid & i_en & ~i_start;
  assign o_row_last  = o_valid & w_col_at_limit;
  assign w_last_elem = w_col_at_limit & w_row_at_limit;

  // On the final pair both counters hold so the indices stay put after completion.
  assign w_col_inc = o_step & ~w_last_elem;
  assign w_row_inc = o_step & w_col_at_limit & ~w_row_at_limit;

  wrap_counter #(.W(SIZE_ADDR)) u_col_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_start),
    .i_inc      (w_col_inc),
    .i_limit    (w_col_limit),
    .o_value    (o_col_j),
    .o_at_limit (w_col_at_limit)
  );

  wrap_counter #(.W(SIZE_ADDR)) u_row_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_start),
    .i_inc      (w_row_inc),
    .i_limit    (r_last_row),
    .o_value    (o_row_i),
    .o_at_limit (w_row_at_limit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  // A zero-sized start completes immediately; a restart in RUN never reports
  // completion for the sweep it abandons.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    if (i_start) begin
      if (w_zero_size) begin
        w_state_next = ST_IDLE;
        w_done_next  = 1'b1;
      end else begin
        w_state_next = ST_RUN;
      end
    end else if (r_state == ST_RUN && o_step && w_last_elem) begin
      w_state_next = ST_IDLE;
      w_done_next  = 1'b1;
    end
  end

  assign o_done = r_done;

endmodule

// File: tb/tb_nested_index_gen.sv
// tb/tb_nested_index_gen.sv - directed self-checking bench for nested_index_gen
module tb_nested_index_gen;

  localparam int W = 8;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start;
  logic         i_en;
  logic [W-1:0] i_num_rows;
  logic [W-1:0] i_num_cols;
  logic         o_valid;
  logic         o_step;
  logic [W-1:0] o_row_i;
  logic [W-1:0] o_col_j;
  logic         o_row_last;
  logic         o_busy;
  logic         o_done;

  int checks;
  int errors;

  nested_index_gen #(.SIZE_ADDR(W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_en       (i_en),
    .i_num_rows (i_num_rows),
    .i_num_cols (i_num_cols),
    .o_valid    (o_valid),
    .o_step     (o_step),
    .o_row_i    (o_row_i),
    .o_col_j    (o_col_j),
    .o_row_last (o_row_last),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and samples happen 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Check every output against expectations (sampled after inputs have settled).
  task automatic chk_all(input string tag, input int v, input int st, input int r,
                         input int c, input int rl, input int b, input int d);
    #1;
    chk({tag, ".valid"},    32'(o_valid),    32'(v));
    chk({tag, ".step"},     32'(o_step),     32'(st));
    chk({tag, ".row"},      32'(o_row_i),    32'(r));
    chk({tag, ".col"},      32'(o_col_j),    32'(c));
    chk({tag, ".row_last"}, 32'(o_row_last), 32'(rl));
    chk({tag, ".busy"},     32'(o_busy),     32'(b));
    chk({tag, ".done"},     32'(o_done),     32'(d));
  endtask

  task automatic start_sweep(input int rows, input int cols);
    i_start    = 1'b1;
    i_num_rows = W'(rows);
    i_num_cols = W'(cols);
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_en       = 1'b0;
    i_num_rows = '0;
    i_num_cols = '0;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    chk_all("idle", 0, 0, 0, 0, 0, 0, 0);

`ifdef NESTED_IDX_TRIANGULAR_EN
    // Lower triangle of R=3; column count is ignored.
    begin
      int tri_r[6] = '{0, 1, 1, 2, 2, 2};
      int tri_c[6] = '{0, 0, 1, 0, 1, 2};
      i_en = 1'b1;
      start_sweep(3, 0);
      for (int k = 0; k < 6; k++) begin
        chk_all($sformatf("tri[%0d]", k), 1, 1, tri_r[k], tri_c[k],
                (tri_c[k] == tri_r[k]) ? 1 : 0, 1, 0);
        tick();
      end
      chk_all("tri_done", 0, 0, 2, 2, 0, 0, 1);
      tick();
      chk_all("tri_done_clr", 0, 0, 2, 2, 0, 0, 0);
    end

    // Zero rows in triangular mode: completes immediately regardless of columns.
    start_sweep(0, 7);
    chk_all("tri_zero", 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("tri_zero_clr", 0, 0, 0, 0, 0, 0, 0);
`else
    // R=3, C=4 with i_en held high: 12 pairs in row-major order, then done.
    i_en = 1'b1;
    start_sweep(3, 4);
    for (int k = 0; k < 12; k++) begin
      chk_all($sformatf("r3c4[%0d]", k), 1, 1, k / 4, k % 4, (k % 4 == 3) ? 1 : 0, 1, 0);
      tick();
    end
    chk_all("r3c4_done", 0, 0, 2, 3, 0, 0, 1);
    tick();
    chk_all("r3c4_done_clr", 0, 0, 2, 3, 0, 0, 0);

    // R=2, C=2 with i_en alternating 0/1: each pair holds across the stall.
    i_en = 1'b0;
    start_sweep(2, 2);
    for (int k = 0; k < 4; k++) begin
      i_en = 1'b0;
      chk_all($sformatf("stall_hold[%0d]", k), 1, 0, k / 2, k % 2, k % 2, 1, 0);
      tick();
      i_en = 1'b1;
      chk_all($sformatf("stall_go[%0d]", k), 1, 1, k / 2, k % 2, k % 2, 1, 0);
      tick();
    end
    i_en = 1'b0;
    chk_all("stall_done", 0, 0, 1, 1, 0, 0, 1);
    tick();
    chk_all("stall_done_clr", 0, 0, 1, 1, 0, 0, 0);

    // Zero rows: never valid, done pulses in the following cycle only.
    i_en = 1'b1;
    i_start    = 1'b1;
    i_num_rows = W'(0);
    i_num_cols = W'(5);
    chk_all("zero_start", 0, 0, 1, 1, 0, 0, 0);
    tick();
    i_start = 1'b0;
    chk_all("zero_done", 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("zero_done_clr", 0, 0, 0, 0, 0, 0, 0);

    // Restart at (1,2) with R=1, C=3: start beats i_en, no done for aborted sweep.
    start_sweep(3, 4);
    for (int k = 0; k < 6; k++) tick();
    i_start    = 1'b1;
    i_num_rows = W'(1);
    i_num_cols = W'(3);
    chk_all("restart_at", 1, 0, 1, 2, 0, 1, 0);
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_all($sformatf("restart[%0d]", k), 1, 1, 0, k, (k == 2) ? 1 : 0, 1, 0);
      tick();
    end
    chk_all("restart_done", 0, 0, 0, 2, 0, 0, 1);
    tick();

    // Bound inputs changing mid-sweep are ignored.
    start_sweep(1, 2);
    i_num_rows = W'(9);
    i_num_cols = W'(9);
    chk_all("ign[0]", 1, 1, 0, 0, 0, 1, 0);
    tick();
    chk_all("ign[1]", 1, 1, 0, 1, 1, 1, 0);
    tick();
    chk_all("ign_done", 0, 0, 0, 1, 0, 0, 1);
    tick();

    // Maximum row bound: R=255, C=2, full sweep with no overflow.
    start_sweep(255, 2);
    for (int k = 0; k < 510; k++) begin
      chk($sformatf("max_row[%0d]", k), 32'(o_row_i), 32'(k / 2));
      chk($sformatf("max_col[%0d]", k), 32'(o_col_j), 32'(k % 2));
      tick();
    end
    chk_all("max_done", 0, 0, 254, 1, 0, 0, 1);
    tick();

    // Reset at (2,1): outputs clear immediately, no done afterwards.
    start_sweep(3, 4);
    for (int k = 0; k < 9; k++) tick();
    chk_all("pre_reset", 1, 1, 2, 1, 0, 1, 0);
    i_rst_n = 1'b0;
    chk_all("in_reset", 0, 0, 0, 0, 0, 0, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk_all("post_reset0", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_all("post_reset1", 0, 0, 0, 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
